// File: rtl/jk_excite_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excite_counter_pkg
//  Description : JK input encodings and the excitation (inverse characteristic)
//                function shared by the JK counter and FSM labs.
//  Revision    : 1.0 - initial release
// ============================================================================
package jk_excite_counter_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Returns {J,K}; don't-cares resolve to 0, so a change is always set or reset, never toggle.
    function automatic logic [1:0] jk_excite(input logic q_now, input logic q_next);
        if (q_now == q_next) begin
            return JK_HOLD;
        end else if (q_next) begin
            return JK_SET;
        end else begin
            return JK_RST;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_excite_counter_jk_cell.sv
`default_nettype none
// ============================================================================
//  Module      : jk_cell
//  Description : Single JK storage bit with asynchronous active-low reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_cell
    import jk_excite_counter_pkg::*;
(
    input  logic C,
    input  logic RN,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case ({J, K})
            JK_HOLD: q_d = q_q;
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
        endcase
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule
`default_nettype wire

// File: rtl/jk_excite_counter.sv
`default_nettype none
// ============================================================================
//  Module      : jk_excite_counter
//  Description : Loadable up/down mod-MOD counter built from JK cells driven
//                through the JK excitation table.
//  Revision    : 1.0 - initial release
// ============================================================================
module jk_excite_counter
    import jk_excite_counter_pkg::*;
#(
    parameter int W   = 4,
    parameter int MOD = 10
) (
    input  logic         C,
    input  logic         RN,
    input  logic         EN,
    input  logic         UD,
    input  logic         LD,
    input  logic [W-1:0] DIN,
    output logic [W-1:0] Q,
    output logic [W-1:0] Qb,
    output logic         TC,
    output logic [W-1:0] JX,
    output logic [W-1:0] KX
);

    localparam logic [W-1:0] C_TOP = W'(MOD - 1);

    logic [W-1:0] q_w;
    logic [W-1:0] n_d;
    logic         at_top;
    logic         at_zero;
    logic         q_valid;

    always_comb begin
        at_top  = (q_w == C_TOP);
        at_zero = (q_w == '0);
        q_valid = (32'(q_w) < MOD);

        // Out-of-range states (only reachable by corruption) recover to 0.
        if (LD) begin
            n_d = (32'(DIN) < MOD) ? DIN : '0;
        end else if (!EN) begin
            n_d = q_w;
        end else if (!q_valid) begin
            n_d = '0;
        end else if (UD) begin
            n_d = at_top ? '0 : q_w + W'(1);
        end else begin
            n_d = at_zero ? C_TOP : q_w - W'(1);
        end

        JX = '0;
        KX = '0;
        for (int i = 0; i < W; i++) begin
            {JX[i], KX[i]} = RN ? jk_excite(q_w[i], n_d[i]) : JK_HOLD;
        end

        TC = RN & EN & ~LD & ((UD & at_top) | (~UD & at_zero));
    end

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        jk_cell u_cell (
            .C  (C),
            .RN (RN),
            .J  (JX[gi]),
            .K  (KX[gi]),
            .Q  (q_w[gi])
        );
    end

    assign Q  = q_w;
    assign Qb = ~q_w;

endmodule
`default_nettype wire

// File: tb/tb_jk_excite_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jk_excite_counter
//  Description : Self-checking bench for jk_excite_counter at MOD=10, 16 and 2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_excite_counter;

    logic       C   = 1'b0;
    logic       RN  = 1'b0;
    logic       EN  = 1'b0;
    logic       UD  = 1'b1;
    logic       LD  = 1'b0;
    logic [3:0] DIN = 4'd0;

    logic [3:0] dq  [3];
    logic [3:0] dqb [3];
    logic [3:0] djx [3];
    logic [3:0] dkx [3];
    logic       dtc [3];

    int total = 0;
    int bad   = 0;
    int mq [3] = '{0, 0, 0};
    int pq [3] = '{0, 0, 0};
    int pjx[3] = '{0, 0, 0};
    int pkx[3] = '{0, 0, 0};
    bit have_prev = 1'b0;
    bit rst_seen  = 1'b1;
    bit chk_on    = 1'b0;

    jk_excite_counter #(.W(4), .MOD(10)) u_dut10 (
        .C(C), .RN(RN), .EN(EN), .UD(UD), .LD(LD), .DIN(DIN),
        .Q(dq[0]), .Qb(dqb[0]), .TC(dtc[0]), .JX(djx[0]), .KX(dkx[0])
    );
    jk_excite_counter #(.W(4), .MOD(16)) u_dut16 (
        .C(C), .RN(RN), .EN(EN), .UD(UD), .LD(LD), .DIN(DIN),
        .Q(dq[1]), .Qb(dqb[1]), .TC(dtc[1]), .JX(djx[1]), .KX(dkx[1])
    );
    jk_excite_counter #(.W(4), .MOD(2)) u_dut2 (
        .C(C), .RN(RN), .EN(EN), .UD(UD), .LD(LD), .DIN(DIN),
        .Q(dq[2]), .Qb(dqb[2]), .TC(dtc[2]), .JX(djx[2]), .KX(dkx[2])
    );

    initial forever #5 C = ~C;

    function automatic int mod_of(int k);
        return (k == 0) ? 10 : (k == 1) ? 16 : 2;
    endfunction

    // Reference next state straight from the counting rules.
    function automatic int m_next(int q, int m);
        if (LD) return (int'(DIN) < m) ? int'(DIN) : 0;
        if (!EN) return q;
        if (q >= m) return 0;
        return UD ? (q + 1) % m : (q + m - 1) % m;
    endfunction

    task automatic check(string nm, int k, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s[mod%0d] t=%0t got=%0d exp=%0d", nm, mod_of(k), $time, got, exp);
        end
    endtask

    always @(posedge C or negedge RN) begin
        for (int k = 0; k < 3; k++) begin
            mq[k] = RN ? m_next(mq[k], mod_of(k)) : 0;
        end
    end

    always @(negedge RN) rst_seen = 1'b1;

    always @(negedge C) begin
        if (chk_on) begin
            for (int k = 0; k < 3; k++) begin
                int m, n, ejx, ekx, etc;
                m   = mod_of(k);
                n   = m_next(mq[k], m);
                ejx = RN ? ((~mq[k] & n) & 15) : 0;
                ekx = RN ? ((mq[k] & ~n) & 15) : 0;
                etc = (RN && EN && !LD && ((UD && mq[k] == m - 1) || (!UD && mq[k] == 0))) ? 1 : 0;
                check("Q",  k, int'(dq[k]),  mq[k]);
                check("Qb", k, int'(dqb[k]), (~mq[k]) & 15);
                check("JX", k, int'(djx[k]), ejx);
                check("KX", k, int'(dkx[k]), ekx);
                check("TC", k, int'(dtc[k]), etc);
                check("jk_excl", k, int'(djx[k] & dkx[k]), 0);
                if (have_prev && !rst_seen) begin
                    check("jk_char", k, int'(dq[k]), (pq[k] & ~pkx[k]) | (~pq[k] & pjx[k]));
                end
                pq[k]  = int'(dq[k]);
                pjx[k] = int'(djx[k]);
                pkx[k] = int'(dkx[k]);
            end
            have_prev = 1'b1;
            rst_seen  = !RN;
        end
    end

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        EN = 1'b1;
        UD = 1'b0;
        chk_on = 1'b1;
        #2;
        check("rst_Q",  0, int'(dq[0]),  0);
        check("rst_Qb", 0, int'(dqb[0]), 15);
        check("rst_TC", 0, int'(dtc[0]), 0);
        check("rst_JX", 0, int'(djx[0]), 0);
        check("rst_KX", 0, int'(dkx[0]), 0);
        tick();
        tick();

        RN = 1'b1; EN = 1'b1; UD = 1'b1; LD = 1'b0;
        for (int i = 0; i < 12; i++) begin
            #1;
            check("up_TC", 0, int'(dtc[0]), (i == 9) ? 1 : 0);
            if (i == 9) begin
                check("wrap_JX", 0, int'(djx[0]), 0);
                check("wrap_KX", 0, int'(dkx[0]), 9);
            end
            tick();
            check("up_Q", 0, int'(dq[0]), up_seq[i]);
        end

        LD = 1'b1; DIN = 4'd7;
        tick();
        LD = 1'b0;
        check("pre_rst_Q", 0, int'(dq[0]), 7);
        #2;
        RN = 1'b0;
        #1;
        check("mid_rst_Q",  0, int'(dq[0]),  0);
        check("mid_rst_Qb", 0, int'(dqb[0]), 15);
        check("mid_rst_TC", 0, int'(dtc[0]), 0);
        check("mid_rst_JX", 0, int'(djx[0]), 0);
        check("mid_rst_KX", 0, int'(dkx[0]), 0);
        tick();
        check("rst_hold_Q", 0, int'(dq[0]), 0);
        RN = 1'b1;

        UD = 1'b0;
        #1;
        check("dn_TC0", 0, int'(dtc[0]), 1);
        tick();
        check("dn_Q9", 0, int'(dq[0]), 9);
        tick();
        check("dn_Q8", 0, int'(dq[0]), 8);

        LD = 1'b1; DIN = 4'd5; tick();
        LD = 1'b0; UD = 1'b1; tick();
        check("ud_up6", 0, int'(dq[0]), 6);
        LD = 1'b1; DIN = 4'd5; tick();
        LD = 1'b0; UD = 1'b0; tick();
        check("ud_dn4", 0, int'(dq[0]), 4);

        LD = 1'b1; DIN = 4'd9; tick();
        EN = 1'b1; UD = 1'b1; DIN = 4'd3;
        #1;
        check("ld_en_TC", 0, int'(dtc[0]), 0);
        tick();
        check("ld_Q3", 0, int'(dq[0]), 3);
        DIN = 4'd12; tick();
        check("ld_big_Q",   0, int'(dq[0]), 0);
        check("ld_big_Q16", 1, int'(dq[1]), 12);
        check("ld_big_Q2",  2, int'(dq[2]), 0);

        DIN = 4'd6; tick();
        LD = 1'b0; EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("hold_JX", 0, int'(djx[0]), 0);
            check("hold_KX", 0, int'(dkx[0]), 0);
            check("hold_TC", 0, int'(dtc[0]), 0);
            tick();
            check("hold_Q", 0, int'(dq[0]), 6);
        end

        for (int i = 0; i < 400; i++) begin
            EN  = ($urandom_range(0, 3) != 0);
            UD  = 1'($urandom);
            LD  = ($urandom_range(0, 7) == 0);
            DIN = 4'($urandom);
            RN  = ($urandom_range(0, 39) != 0);
            tick();
        end

        RN = 1'b1; LD = 1'b0;
        tick();
        tick();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
